// File: rtl/aes_state_pkg.sv
// Shared AES state types and the column-major byte index used by the
// serializer and the matching deserializer.
package aes_state_pkg;

    typedef logic [7:0] byte_t;

    localparam int ROWS       = 4;
    localparam int NB_DEFAULT = 4;

    // Modules with a different column count declare their own byte_t [ROWS][NB] arrays
    typedef byte_t state_t [ROWS][NB_DEFAULT];

    typedef enum logic {
        IDLE,
        SEND
    } ser_state_t;

    function automatic int flat_index(input int r, input int c);
        return ROWS * c + r;
    endfunction

endpackage

// File: rtl/state_flatten.sv
// Combinational mapping of a 4 x NB byte matrix onto a flat word:
// byte (r,c) lands at byte lane 4*c+r, so column NB-1 row 3 is the MSB.
module state_flatten
    import aes_state_pkg::*;
#(
    parameter int NB = 4
) (
    input  byte_t              matrix [ROWS][NB],
    output logic [32*NB-1:0]   flat
);

    always_comb begin
        flat = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                flat[8*flat_index(r, c) +: 8] = matrix[r][c];
            end
        end
    end

endmodule

// File: rtl/aes_state_serializer.sv
// Captures a flattened AES state on the input handshake and streams it out
// as OUT_W-bit beats; supports abort and counts fully transmitted blocks.
module aes_state_serializer
    import aes_state_pkg::*;
#(
    parameter int NB        = 4,
    parameter int OUT_W     = 32,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  byte_t                in_matrix [ROWS][NB],
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_first,
    output logic                 out_last,
    output logic [32*NB-1:0]     out_raw,
    output logic [CNT_W-1:0]     blocks_done
);

    localparam int STATE_W  = 32 * NB;
    localparam int BEATS    = STATE_W / OUT_W;
    localparam int CNT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;

    ser_state_t             state;
    logic [CNT_BITS-1:0]    cnt;
    logic [STATE_W-1:0]     hold;
    logic [STATE_W-1:0]     flat_in;
    logic                   load;

    state_flatten #(.NB(NB)) u_flatten (
        .matrix (in_matrix),
        .flat   (flat_in)
    );

    function automatic logic [OUT_W-1:0] beat_of(input logic [STATE_W-1:0] f, input int i);
        if (MSB_FIRST != 0) begin
            return f[STATE_W-1-i*OUT_W -: OUT_W];
        end else begin
            return f[i*OUT_W +: OUT_W];
        end
    endfunction

    // A new block may enter while idle, or while the last beat of the current one leaves
    assign in_ready = !abort && (state == IDLE || (state == SEND && out_ready && out_last));
    assign load     = in_valid && in_ready;
    assign out_raw  = hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            hold        <= '0;
            blocks_done <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_first   <= 1'b0;
            out_last    <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            // Reload on the final beat finishes the old block with no bubble
            if (state == SEND) begin
                blocks_done <= blocks_done + 1'b1;
            end
            state     <= SEND;
            hold      <= flat_in;
            cnt       <= '0;
            out_valid <= 1'b1;
            out_data  <= beat_of(flat_in, 0);
            out_first <= 1'b1;
            out_last  <= (BEATS == 1);
        end else if (state == SEND && out_ready) begin
            if (out_last) begin
                blocks_done <= blocks_done + 1'b1;
                state       <= IDLE;
                cnt         <= '0;
                out_valid   <= 1'b0;
                out_first   <= 1'b0;
                out_last    <= 1'b0;
            end else begin
                cnt       <= cnt + 1'b1;
                out_data  <= beat_of(hold, int'(cnt) + 1);
                out_first <= 1'b0;
                out_last  <= (int'(cnt) + 2 == BEATS);
            end
        end
    end

endmodule

// File: tb/tb_aes_state_serializer.sv
// Bench for aes_state_serializer: four configurations side by side, checked
// against a byte-arithmetic model of flattening and beat slicing.
module tb_aes_state_serializer;
    import aes_state_pkg::*;

    typedef struct {
        byte_t        m [4][4];
        logic [127:0] exp_raw;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [3:0]   in_valid_v;
    logic [3:0]   abort_v;
    logic [3:0]   out_ready_v;
    wire  [3:0]   in_ready_v;
    wire  [3:0]   out_valid_v;
    wire  [3:0]   out_first_v;
    wire  [3:0]   out_last_v;
    byte_t        mat [4][4];
    wire  [31:0]  data_a;
    wire  [31:0]  data_b;
    wire  [7:0]   data_c;
    wire  [127:0] data_d;
    wire  [127:0] raw_a;
    wire  [127:0] raw_b;
    wire  [127:0] raw_c;
    wire  [127:0] raw_d;
    wire  [15:0]  done_a;
    wire  [15:0]  done_b;
    wire  [15:0]  done_c;
    wire  [1:0]   done_d;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_done [4];
    vec_t tv [6];

    aes_state_serializer #(.NB(4), .OUT_W(32), .MSB_FIRST(1), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_matrix(mat), .abort(abort_v[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .out_data(data_a), .out_first(out_first_v[0]), .out_last(out_last_v[0]),
        .out_raw(raw_a), .blocks_done(done_a));

    aes_state_serializer #(.NB(4), .OUT_W(32), .MSB_FIRST(0), .CNT_W(16)) u_b (
        .clk(clk), .reset(reset), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_matrix(mat), .abort(abort_v[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .out_data(data_b), .out_first(out_first_v[1]), .out_last(out_last_v[1]),
        .out_raw(raw_b), .blocks_done(done_b));

    aes_state_serializer #(.NB(4), .OUT_W(8), .MSB_FIRST(1), .CNT_W(16)) u_c (
        .clk(clk), .reset(reset), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .in_matrix(mat), .abort(abort_v[2]), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .out_data(data_c), .out_first(out_first_v[2]), .out_last(out_last_v[2]),
        .out_raw(raw_c), .blocks_done(done_c));

    aes_state_serializer #(.NB(4), .OUT_W(128), .MSB_FIRST(1), .CNT_W(2)) u_d (
        .clk(clk), .reset(reset), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
        .in_matrix(mat), .abort(abort_v[3]), .out_valid(out_valid_v[3]), .out_ready(out_ready_v[3]),
        .out_data(data_d), .out_first(out_first_v[3]), .out_last(out_last_v[3]),
        .out_raw(raw_d), .blocks_done(done_d));

    function automatic logic [127:0] get_data(input int sel);
        case (sel)
            0:       return {96'b0, data_a};
            1:       return {96'b0, data_b};
            2:       return {120'b0, data_c};
            default: return data_d;
        endcase
    endfunction

    function automatic logic [127:0] get_raw(input int sel);
        case (sel)
            0:       return raw_a;
            1:       return raw_b;
            2:       return raw_c;
            default: return raw_d;
        endcase
    endfunction

    function automatic int get_done(input int sel);
        case (sel)
            0:       return int'(done_a);
            1:       return int'(done_b);
            2:       return int'(done_c);
            default: return int'(done_d);
        endcase
    endfunction

    function automatic int width_of(input int sel);
        case (sel)
            2:       return 8;
            3:       return 128;
            default: return 32;
        endcase
    endfunction

    function automatic int cnt_mod(input int sel);
        return (sel == 3) ? 4 : 65536;
    endfunction

    // Reference: byte (r,c) is the (4c+r)-th byte of the word, counted from the LSB
    function automatic logic [127:0] model_flat(input byte_t m [4][4]);
        logic [127:0] f;
        f = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                f = f | (128'(m[r][c]) << (8 * (4 * c + r)));
            end
        end
        return f;
    endfunction

    function automatic logic [127:0] model_beat(input logic [127:0] f, input int w, input bit msb, input int i);
        logic [127:0] mask;
        mask = {128{1'b1}} >> (128 - w);
        if (msb) return (f >> (128 - (i + 1) * w)) & mask;
        return (f >> (i * w)) & mask;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Load one block (unless already preloaded) and drain all its beats; with chain,
    // the next matrix is offered on the final beat so it loads with no gap.
    task automatic applyStimulus(input int sel, input byte_t m [4][4], input logic [127:0] exp_raw,
                                 input int mode, input bit preloaded, input bit chain,
                                 input byte_t nm [4][4]);
        int w;
        int beats;
        bit msb;
        int i;
        int budget;
        bit rdy;
        w      = width_of(sel);
        beats  = 128 / w;
        msb    = (sel != 1);
        i      = 0;
        budget = 0;
        if (!preloaded) begin
            mat = m;
            in_valid_v[sel] = 1'b1;
            #1;
            while (!in_ready_v[sel] && budget < 50) begin
                tick();
                budget++;
            end
            checkOutput("accept_ready", 128'(in_ready_v[sel]), 128'(1));
            tick();
            in_valid_v[sel] = 1'b0;
        end
        budget = 0;
        while (i < beats && budget < 400) begin
            checkOutput("beat_valid", 128'(out_valid_v[sel]), 128'(1));
            checkOutput("beat_data", get_data(sel), model_beat(exp_raw, w, msb, i));
            checkOutput("beat_first", 128'(out_first_v[sel]), 128'(i == 0));
            checkOutput("beat_last", 128'(out_last_v[sel]), 128'(i == beats - 1));
            checkOutput("raw_hold", get_raw(sel), exp_raw);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (budget % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (chain && i == beats - 1) begin
                rdy = 1'b1;
                mat = nm;
                in_valid_v[sel] = 1'b1;
            end
            out_ready_v[sel] = rdy;
            #1;
            if (chain && i == beats - 1) checkOutput("chain_ready", 128'(in_ready_v[sel]), 128'(1));
            tick();
            if (rdy) i++;
            budget++;
        end
        checkOutput("beats_sent", 128'(i), 128'(beats));
        in_valid_v[sel]  = 1'b0;
        out_ready_v[sel] = 1'b0;
        exp_done[sel]++;
        checkOutput("blocks_done", 128'(get_done(sel)), 128'(exp_done[sel] % cnt_mod(sel)));
        checkOutput("valid_after", 128'(out_valid_v[sel]), 128'(chain));
    endtask

    task automatic check_reset_state(input string tag);
        for (int s = 0; s < 4; s++) begin
            checkOutput({tag, "_valid"}, 128'(out_valid_v[s]), 128'(0));
            checkOutput({tag, "_data"}, get_data(s), 128'(0));
            checkOutput({tag, "_raw"}, get_raw(s), 128'(0));
            checkOutput({tag, "_first"}, 128'(out_first_v[s]), 128'(0));
            checkOutput({tag, "_last"}, 128'(out_last_v[s]), 128'(0));
            checkOutput({tag, "_done"}, 128'(get_done(s)), 128'(0));
            checkOutput({tag, "_in_ready"}, 128'(in_ready_v[s]), 128'(1));
        end
    endtask

    initial begin
        in_valid_v  = '0;
        abort_v     = '0;
        out_ready_v = '0;
        reset       = 1'b1;
        for (int s = 0; s < 4; s++) exp_done[s] = 0;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) mat[r][c] = 8'h00;

        tv[0].m[3] = '{8'h77, 8'h74, 8'h63, 8'h12};
        tv[0].m[2] = '{8'h05, 8'h62, 8'h7a, 8'h1b};
        tv[0].m[1] = '{8'h64, 8'h0d, 8'h12, 8'h19};
        tv[0].m[0] = '{8'h58, 8'h15, 8'h79, 8'h04};
        tv[0].exp_raw = 128'h121b1904637a127974620d1577056458;
        for (int k = 1; k < 6; k++) begin
            for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) tv[k].m[r][c] = 8'($urandom);
            tv[k].exp_raw = model_flat(tv[k].m);
        end

        tick();
        tick();
        reset = 1'b0;
        check_reset_state("reset");

        $display("[TB] basic and reversed streams");
        applyStimulus(0, tv[0].m, tv[0].exp_raw, 0, 1'b0, 1'b0, tv[0].m);
        applyStimulus(1, tv[0].m, tv[0].exp_raw, 0, 1'b0, 1'b0, tv[0].m);

        $display("[TB] random vectors with random backpressure");
        for (int k = 1; k < 6; k++) begin
            applyStimulus(0, tv[k].m, tv[k].exp_raw, 2, 1'b0, 1'b0, tv[k].m);
            applyStimulus(1, tv[k].m, tv[k].exp_raw, 2, 1'b0, 1'b0, tv[k].m);
        end

        $display("[TB] byte beats back to back with toggled ready");
        applyStimulus(2, tv[0].m, tv[0].exp_raw, 1, 1'b0, 1'b1, tv[1].m);
        applyStimulus(2, tv[1].m, tv[1].exp_raw, 1, 1'b1, 1'b0, tv[1].m);
        checkOutput("b2b_done", 128'(done_c), 128'(2));

        $display("[TB] abort after two beats");
        mat = tv[0].m;
        in_valid_v[0]  = 1'b1;
        out_ready_v[0] = 1'b1;
        tick();
        in_valid_v[0] = 1'b0;
        tick();
        tick();
        checkOutput("abort_beat2", get_data(0), model_beat(tv[0].exp_raw, 32, 1'b1, 2));
        abort_v[0]    = 1'b1;
        mat           = tv[2].m;
        in_valid_v[0] = 1'b1;
        #1;
        checkOutput("abort_in_ready", 128'(in_ready_v[0]), 128'(0));
        tick();
        abort_v[0]     = 1'b0;
        in_valid_v[0]  = 1'b0;
        out_ready_v[0] = 1'b0;
        checkOutput("abort_valid", 128'(out_valid_v[0]), 128'(0));
        checkOutput("abort_done", 128'(get_done(0)), 128'(exp_done[0]));
        checkOutput("abort_raw", get_raw(0), tv[0].exp_raw);
        applyStimulus(0, tv[3].m, tv[3].exp_raw, 0, 1'b0, 1'b0, tv[3].m);

        $display("[TB] reset in the middle of a block");
        mat = tv[4].m;
        in_valid_v[0]  = 1'b1;
        out_ready_v[0] = 1'b1;
        tick();
        in_valid_v[0] = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready_v[0] = 1'b0;
        for (int s = 0; s < 4; s++) exp_done[s] = 0;
        check_reset_state("midreset");

        $display("[TB] single wide beat and counter wrap");
        applyStimulus(3, tv[1].m, tv[1].exp_raw, 0, 1'b0, 1'b1, tv[2].m);
        applyStimulus(3, tv[2].m, tv[2].exp_raw, 0, 1'b1, 1'b1, tv[3].m);
        applyStimulus(3, tv[3].m, tv[3].exp_raw, 0, 1'b1, 1'b0, tv[3].m);
        applyStimulus(3, tv[4].m, tv[4].exp_raw, 2, 1'b0, 1'b0, tv[4].m);
        applyStimulus(3, tv[5].m, tv[5].exp_raw, 2, 1'b0, 1'b0, tv[5].m);
        checkOutput("wrap_done", 128'(done_d), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
